// File: rtl/burst_rr_arbiter_pkg.sv
// Shared types and helpers for the burst round-robin arbiter.
// Holds the FSM encoding and the index-width helper.
package burst_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int gw_of(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_rr_arbiter_if.sv
// Source-side and sink-side bundle of the burst round-robin arbiter.
// master = arbiter side, slave = sources/sink side.
interface burst_rr_arbiter_if #(
  parameter int WIDTH = 10,
  parameter int DW    = 32,
  parameter int GW    = 4
);

  logic [WIDTH-1:0]    CH_ENABLE;
  logic [WIDTH-1:0]    WRITE_REQ;
  logic [WIDTH*DW-1:0] DATA_IN;
  logic [WIDTH-1:0]    READ_GRANT;
  logic                READY_IN;
  logic                WRITE_OUT;
  logic [DW-1:0]       DATA_OUT;
  logic [GW-1:0]       GRANT_ID;
  logic [31:0]         WORD_CNT;

  modport master (
    input  CH_ENABLE, WRITE_REQ, DATA_IN, READY_IN,
    output READ_GRANT, WRITE_OUT, DATA_OUT,
    output GRANT_ID, WORD_CNT
  );

  modport slave (
    output CH_ENABLE, WRITE_REQ, DATA_IN, READY_IN,
    input  READ_GRANT, WRITE_OUT, DATA_OUT,
    input  GRANT_ID, WORD_CNT
  );

endinterface

// File: rtl/burst_rr_arbiter_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping.
// Double-width copy keeps the wrap a plain mask-and-find-first.
module rr_pick #(
  parameter int WIDTH = 10,
  parameter int GW    = 4
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [GW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [GW-1:0]    idx_o
);

  logic [2*WIDTH-1:0] keep;

  assign keep = {req_i, req_i} & ({(2*WIDTH){1'b1}} << ptr_i);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int j = 2*WIDTH-1; j >= 0; j--)
      if (keep[j]) idx_o = GW'(j % WIDTH);
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with per-grant burst quota merging FWFT sources
// onto one registered output stream.
module burst_rr_arbiter
  import burst_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int BCW       = 5
) (
  input  logic               BUS_CLK,
  input  logic               BUS_RST,
  burst_rr_arbiter_if.master bus
);

  localparam int GW = gw_of(WIDTH);

  state_e         state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  gid_q, gid_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0]  data_q, data_d;
  logic           wr_q, wr_d;
  logic [31:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] elig;
  logic             can_load, pick_v, pop, last;
  logic [GW-1:0]    pick_idx, gid_nx;

  assign elig     = bus.WRITE_REQ & bus.CH_ENABLE;
  assign can_load = ~wr_q | bus.READY_IN;
  assign gid_nx   = (gid_q == GW'(WIDTH-1)) ? '0 : gid_q + 1'b1;
  assign last     = (bcnt_q == BCW'(MAX_BURST-1));

  // No pop while reset is held: the word would be dropped anyway.
  assign pop = (state_q == ST_BURST) & elig[gid_q]
             & can_load & ~BUS_RST;

  rr_pick #(
    .WIDTH (WIDTH),
    .GW    (GW)
  ) u_pick (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .valid_o (pick_v),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_v) begin
          state_d = ST_BURST;
          gid_d   = pick_idx;
          bcnt_d  = '0;
        end
      end
      ST_BURST: begin
        if (!elig[gid_q]) begin
          state_d = ST_IDLE;
          ptr_d   = gid_nx;
        end else if (pop) begin
          bcnt_d = bcnt_q + 1'b1;
          if (last) begin
            state_d = ST_IDLE;
            ptr_d   = gid_nx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      data_d = bus.DATA_IN[gid_q*DW +: DW];
      wr_d   = 1'b1;
    end else if (bus.READY_IN) begin
      wr_d = 1'b0;
    end

    if (wr_q & bus.READY_IN) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.READ_GRANT = pop ? (WIDTH'(1) << gid_q) : '0;
  assign bus.WRITE_OUT  = wr_q;
  assign bus.DATA_OUT   = data_q;
  assign bus.GRANT_ID   = gid_q;
  assign bus.WORD_CNT   = cnt_q;

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Bench for burst_rr_arbiter: queue-based sources, behavioural model,
// directed scenarios plus a randomized run.
module tb_burst_rr_arbiter;

  localparam int W   = 4;
  localparam int DW  = 32;
  localparam int MB  = 16;
  localparam int BCW = 5;
  localparam int GW  = 2;

  logic clk;
  logic rst;

  burst_rr_arbiter_if #(.WIDTH(W), .DW(DW), .GW(GW)) bus();

  burst_rr_arbiter #(
    .WIDTH(W), .DW(DW), .MAX_BURST(MB), .BCW(BCW)
  ) dut (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] srcq [W][$];
  int          seq [W];
  logic [W-1:0] en;
  logic        rdy;

  int tests;
  int fails;
  int pops[$];
  logic [31:0] outs[$];

  // model state: arbitration and output register, at word level
  bit          m_busy;
  int          m_owner;
  int          m_taken;
  int          m_ptr;
  int          m_gid;
  bit          m_ov;
  logic [31:0] m_od;
  logic [31:0] m_total;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      srcq[i].push_back({i[7:0], seq[i][23:0]});
      seq[i]++;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < W; i++) srcq[i].delete();
  endtask

  task automatic drive();
    bus.CH_ENABLE = en;
    bus.READY_IN  = rdy;
    for (int i = 0; i < W; i++) begin
      bus.WRITE_REQ[i] = (srcq[i].size() > 0);
      bus.DATA_IN[i*DW +: DW] =
        (srcq[i].size() > 0) ? srcq[i][0] : (32'hEEEE0000 | i);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_taken = 0; m_ptr = 0; m_gid = 0;
    m_ov = 0; m_od = '0; m_total = '0;
  endtask

  task automatic step();
    bit          e[W];
    logic [31:0] fr[W];
    bit          exp_pop;
    logic [W-1:0] exp_g;
    int          g;
    drive();
    #1;
    for (int i = 0; i < W; i++) begin
      e[i]  = (srcq[i].size() > 0) && en[i];
      fr[i] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
    exp_pop = m_busy && !rst && e[m_owner] && (!m_ov || rdy);
    exp_g   = exp_pop ? W'(1 << m_owner) : '0;
    chk("read_grant", bus.READ_GRANT, exp_g);
    chk("grant_onehot", $onehot0(bus.READ_GRANT), 1);
    g = -1;
    for (int i = 0; i < W; i++) if (bus.READ_GRANT[i]) g = i;
    @(posedge clk);
    if (g >= 0) begin
      pops.push_back(g);
      if (srcq[g].size() > 0) void'(srcq[g].pop_front());
    end
    if (rst) model_reset();
    else begin
      if (m_ov && rdy) m_total++;
      if (exp_pop) begin m_od = fr[m_owner]; m_ov = 1; end
      else if (rdy) m_ov = 0;
      if (!m_busy) begin
        for (int k = 0; k < W; k++) begin
          int i;
          i = (m_ptr + k) % W;
          if (!m_busy && e[i]) begin
            m_busy = 1; m_owner = i; m_gid = i; m_taken = 0;
          end
        end
      end else if (!e[m_owner]) begin
        m_busy = 0; m_ptr = (m_owner + 1) % W;
      end else if (exp_pop) begin
        m_taken++;
        if (m_taken == MB) begin
          m_busy = 0; m_ptr = (m_owner + 1) % W;
        end
      end
    end
    @(negedge clk);
    chk("write_out", bus.WRITE_OUT, m_ov);
    chk("data_out", bus.DATA_OUT, m_od);
    chk("grant_id", bus.GRANT_ID, m_gid);
    chk("word_cnt", bus.WORD_CNT, m_total);
    if (bus.WRITE_OUT) outs.push_back(bus.DATA_OUT);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    pops.delete();
    outs.delete();
  endtask

  function automatic int cnt_of(input int i);
    int c;
    c = 0;
    foreach (pops[k]) if (pops[k] == i) c++;
    return c;
  endfunction

  function automatic int order_at(input int n);
    int last, idx;
    last = -1; idx = -1;
    foreach (pops[k]) begin
      if (pops[k] != last) begin
        idx++;
        last = pops[k];
        if (idx == n) return last;
      end
    end
    return -1;
  endfunction

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; rdy = 1'b1; en = '1;
    for (int i = 0; i < W; i++) seq[i] = 0;
    model_reset();

    // 1: single source, short run, then pointer check
    do_reset();
    add(2, 5);
    repeat (10) step();
    chk("t1_pops", cnt_of(2), 5);
    chk("t1_wcnt", bus.WORD_CNT, 5);
    chk("t1_first", outs.size() > 0 ? outs[0] : 32'hx, 32'h02000000);
    chk("t1_last", outs.size() > 4 ? outs[4] : 32'hx, 32'h02000004);
    add(0, 1);
    add(3, 1);
    step();
    chk("t1_ptr3", bus.GRANT_ID, 3);
    repeat (8) step();

    // 2: two continuous sources alternate in full bursts
    do_reset();
    clear_all();
    add(0, 40);
    add(1, 40);
    repeat (34) step();
    chk("t2_ch0", cnt_of(0), 16);
    chk("t2_ch1", cnt_of(1), 16);
    chk("t2_first", order_at(0), 0);
    chk("t2_second", order_at(1), 1);
    clear_all();
    repeat (3) step();
    chk("t2_wcnt", bus.WORD_CNT, 32);

    // 3: downstream stall mid-burst
    do_reset();
    clear_all();
    add(1, 16);
    repeat (6) step();
    rdy = 1'b0;
    repeat (3) step();
    chk("t3_stall", pops.size(), 5);
    rdy = 1'b1;
    repeat (20) step();
    chk("t3_pops", cnt_of(1), 16);
    chk("t3_wcnt", bus.WORD_CNT, 16);

    // 4: request drop ends burst, pointer wraps 3 -> 0
    do_reset();
    clear_all();
    add(3, 4);
    step();
    add(0, 5);
    repeat (15) step();
    chk("t4_first", order_at(0), 3);
    chk("t4_second", order_at(1), 0);
    chk("t4_ch3", cnt_of(3), 4);
    chk("t4_ch0", cnt_of(0), 5);

    // 5: masked channel is skipped
    do_reset();
    clear_all();
    en = 4'b1011;
    for (int i = 0; i < W; i++) add(i, 40);
    repeat (70) step();
    chk("t5_ch2", cnt_of(2), 0);
    chk("t5_o0", order_at(0), 0);
    chk("t5_o1", order_at(1), 1);
    chk("t5_o2", order_at(2), 3);
    chk("t5_o3", order_at(3), 0);
    en = '1;

    // 6: reset during a burst with a word held
    do_reset();
    clear_all();
    add(1, 30);
    repeat (5) step();
    chk("t6_pre_wo", bus.WRITE_OUT, 1);
    rst = 1'b1;
    step();
    chk("t6_wo", bus.WRITE_OUT, 0);
    chk("t6_wcnt", bus.WORD_CNT, 0);
    rst = 1'b0;
    add(3, 5);
    drive();
    #1;
    chk("t6_grant", bus.READ_GRANT, 0);
    step();
    chk("t6_lowest", bus.GRANT_ID, 1);
    repeat (10) step();

    // randomized traffic
    do_reset();
    clear_all();
    for (int n = 0; n < 4000; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) en = W'($urandom);
      for (int i = 0; i < W; i++) begin
        if (srcq[i].size() < 3 && $urandom_range(0, 5) == 0)
          add(i, $urandom_range(1, 24));
        if ($urandom_range(0, 199) == 0) srcq[i].delete();
      end
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
